// File: rtl/snake_mem_scheduler.sv
// Snake body RAM owner: arbitrates the single RAM port between game-logic updates
// (init / push head / pop tail) and a per-scanline streaming scan for the renderer.
module snake_mem_scheduler #(
  parameter int unsigned MAX_LEN = 64,
  parameter int unsigned ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              upd_req,
  input  logic [1:0]        upd_op,
  input  logic [4:0]        upd_x,
  input  logic [3:0]        upd_y,
  output logic              upd_ack,
  output logic              full,
  output logic [ADDR_W:0]   length,
  output logic [4:0]        head_x,
  output logic [3:0]        head_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [8:0]        mem_wdata,
  input  logic [8:0]        mem_rdata,
  output logic [4:0]        snake_x,
  output logic [3:0]        snake_y,
  output logic              snake_valid,
  output logic              snake_first,
  output logic              snake_last
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] OP_INIT = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    UPD  = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  head_ptr, head_ptr_nxt;
  logic [ADDR_W-1:0]  tail_ptr, tail_ptr_nxt;
  logic [LEN_W-1:0]   length_nxt;
  logic               full_nxt;
  logic [4:0]         head_x_nxt;
  logic [3:0]         head_y_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic               mem_we_nxt;
  logic [8:0]         mem_wdata_nxt;
  logic               upd_ack_nxt;
  logic [LEN_W-1:0]   scan_cnt, scan_cnt_nxt;
  logic               scan_first, scan_first_nxt;
  logic               valid_nxt, first_nxt, last_nxt;

  // Circular increment; MAX_LEN need not be a power of two.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(MAX_LEN - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Streamed coordinates come straight from the synchronous RAM output.
  assign snake_x = mem_rdata[4:0];
  assign snake_y = mem_rdata[8:5];

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      length      <= '0;
      full        <= 1'b0;
      head_x      <= '0;
      head_y      <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      upd_ack     <= 1'b0;
      scan_cnt    <= '0;
      scan_first  <= 1'b0;
      snake_valid <= 1'b0;
      snake_first <= 1'b0;
      snake_last  <= 1'b0;
    end else begin
      state       <= state_nxt;
      head_ptr    <= head_ptr_nxt;
      tail_ptr    <= tail_ptr_nxt;
      length      <= length_nxt;
      full        <= full_nxt;
      head_x      <= head_x_nxt;
      head_y      <= head_y_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_we      <= mem_we_nxt;
      mem_wdata   <= mem_wdata_nxt;
      upd_ack     <= upd_ack_nxt;
      scan_cnt    <= scan_cnt_nxt;
      scan_first  <= scan_first_nxt;
      snake_valid <= valid_nxt;
      snake_first <= first_nxt;
      snake_last  <= last_nxt;
    end
  end

  // Next-state and output logic. During SCAN, mem_addr doubles as the scan pointer.
  always_comb begin
    state_nxt      = state;
    head_ptr_nxt   = head_ptr;
    tail_ptr_nxt   = tail_ptr;
    length_nxt     = length;
    head_x_nxt     = head_x;
    head_y_nxt     = head_y;
    mem_addr_nxt   = mem_addr;
    mem_we_nxt     = 1'b0;
    mem_wdata_nxt  = mem_wdata;
    upd_ack_nxt    = 1'b0;
    scan_cnt_nxt   = scan_cnt;
    scan_first_nxt = scan_first;
    valid_nxt      = 1'b0;
    first_nxt      = 1'b0;
    last_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (line_start && (length != '0)) begin
          state_nxt      = SCAN;
          mem_addr_nxt   = tail_ptr;
          scan_cnt_nxt   = length;
          scan_first_nxt = 1'b1;
        end else if (upd_req) begin
          state_nxt = UPD;
        end
      end

      SCAN: begin
        valid_nxt      = 1'b1;
        first_nxt      = scan_first;
        last_nxt       = (scan_cnt == LEN_W'(1));
        scan_first_nxt = 1'b0;
        // A new line restarts from the tail; the read issued this cycle still emerges.
        if (line_start) begin
          mem_addr_nxt   = tail_ptr;
          scan_cnt_nxt   = length;
          scan_first_nxt = 1'b1;
        end else begin
          mem_addr_nxt = ptr_inc(mem_addr);
          scan_cnt_nxt = scan_cnt - LEN_W'(1);
          if (scan_cnt == LEN_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end

      UPD: begin
        state_nxt   = ACK;
        upd_ack_nxt = 1'b1;
        case (upd_op)
          OP_INIT: begin
            head_ptr_nxt  = '0;
            tail_ptr_nxt  = '0;
            length_nxt    = LEN_W'(1);
            mem_addr_nxt  = '0;
            mem_we_nxt    = 1'b1;
            mem_wdata_nxt = {upd_y, upd_x};
            head_x_nxt    = upd_x;
            head_y_nxt    = upd_y;
          end
          OP_PUSH: begin
            if (length != LEN_W'(MAX_LEN)) begin
              head_ptr_nxt  = ptr_inc(head_ptr);
              length_nxt    = length + LEN_W'(1);
              mem_addr_nxt  = ptr_inc(head_ptr);
              mem_we_nxt    = 1'b1;
              mem_wdata_nxt = {upd_y, upd_x};
              head_x_nxt    = upd_x;
              head_y_nxt    = upd_y;
            end
          end
          OP_POP: begin
            if (length > LEN_W'(1)) begin
              tail_ptr_nxt = ptr_inc(tail_ptr);
              length_nxt   = length - LEN_W'(1);
            end
          end
          default: ;
        endcase
      end

      ACK: begin
        // Requester drops upd_req while ack is visible, so IDLE never re-triggers.
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    full_nxt = (length_nxt == LEN_W'(MAX_LEN));
  end

endmodule

// File: tb/tb_snake_mem_scheduler.sv
// Randomized scoreboard bench for snake_mem_scheduler with a queue-based body model
// and a behavioural synchronous-read RAM.
module tb_snake_mem_scheduler;

  localparam int unsigned ML = 5;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line_start;
  logic          upd_req;
  logic [1:0]    upd_op;
  logic [4:0]    upd_x;
  logic [3:0]    upd_y;
  logic          upd_ack;
  logic          full;
  logic [AW:0]   length;
  logic [4:0]    head_x;
  logic [3:0]    head_y;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [8:0]    mem_wdata;
  logic [8:0]    mem_rdata;
  logic [4:0]    snake_x;
  logic [3:0]    snake_y;
  logic          snake_valid;
  logic          snake_first;
  logic          snake_last;

  snake_mem_scheduler #(.MAX_LEN(ML), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start),
    .upd_req(upd_req), .upd_op(upd_op), .upd_x(upd_x), .upd_y(upd_y),
    .upd_ack(upd_ack), .full(full), .length(length),
    .head_x(head_x), .head_y(head_y),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .snake_x(snake_x), .snake_y(snake_y), .snake_valid(snake_valid),
    .snake_first(snake_first), .snake_last(snake_last)
  );

  always #5 clk = ~clk;

  logic [8:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [4:0] x; logic [3:0] y; } seg_t;
  typedef struct packed { logic [4:0] x; logic [3:0] y; logic f; logic l; } beat_t;

  seg_t  body[$];
  beat_t exp_q[$];
  logic [4:0] mhx;
  logic [3:0] mhy;
  int vectors = 0;
  int miscompares = 0;

  function automatic void check(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every beat the DUT presents is matched against the scoreboard queue.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && snake_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got x=%0d y=%0d expected no beat (cycle %0d)",
                 snake_x, snake_y, cyc);
      end else begin
        e = exp_q.pop_front();
        check("beat_x", int'(snake_x), int'(e.x));
        check("beat_y", int'(snake_y), int'(e.y));
        check("beat_first", int'(snake_first), int'(e.f));
        check("beat_last", int'(snake_last), int'(e.l));
      end
    end
  end

  // Expected beats for a scan that runs to completion (count = n) or is cut after n issues.
  task automatic push_beats(input int n);
    int sz;
    sz = body.size();
    for (int i = 0; i < n && i < sz; i++) begin
      beat_t b;
      b.x = body[i].x; b.y = body[i].y;
      b.f = (i == 0); b.l = (i == sz - 1);
      exp_q.push_back(b);
    end
  endtask

  function automatic void model_upd(input logic [1:0] op, input logic [4:0] x, input logic [3:0] y);
    seg_t s;
    s.x = x; s.y = y;
    case (op)
      2'd0: begin body.delete(); body.push_back(s); mhx = x; mhy = y; end
      2'd1: if (body.size() < ML) begin body.push_back(s); mhx = x; mhy = y; end
      2'd2: if (body.size() > 1) void'(body.pop_front());
      default: ;
    endcase
  endfunction

  task automatic do_upd(input logic [1:0] op, input logic [4:0] x, input logic [3:0] y,
                        input bit with_ls);
    int start, ack_cyc, n;
    bit got;
    n = body.size();
    @(posedge clk); #1;
    upd_req = 1'b1; upd_op = op; upd_x = x; upd_y = y;
    start = cyc;
    if (with_ls) begin
      line_start = 1'b1;
      push_beats(n);
      @(posedge clk); #1 line_start = 1'b0;
    end
    got = 1'b0;
    ack_cyc = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (upd_ack) begin got = 1'b1; ack_cyc = cyc; end
    end
    check("ack_seen", int'(got), 1);
    if (with_ls) check("ack_after_scan", int'(ack_cyc > start + n), 1);
    model_upd(op, x, y);
    if (got) begin
      check("length", int'(length), body.size());
      check("full", int'(full), int'(body.size() == ML));
      check("head_x", int'(head_x), int'(mhx));
      check("head_y", int'(head_y), int'(mhy));
    end
    @(posedge clk); #1 upd_req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", int'(upd_ack), 0);
  endtask

  task automatic pulse_ls();
    @(posedge clk); #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
  endtask

  task automatic do_scan();
    int n;
    n = body.size();
    push_beats(n);
    pulse_ls();
    if (n > 0) begin
      @(negedge clk);
      check("lat_c1_valid", int'(snake_valid), 0);
      @(negedge clk);
      check("lat_c2_valid", int'(snake_valid), 1);
      check("lat_c2_first", int'(snake_first), 1);
    end
    repeat (n + 3) @(posedge clk);
    @(negedge clk);
    check("scan_drained", exp_q.size(), 0);
  endtask

  // Second line_start arrives k cycles after the first (k >= 2).
  task automatic do_restart(input int k);
    int n;
    n = body.size();
    push_beats(k);
    push_beats(n);
    pulse_ls();
    repeat (k - 2) @(posedge clk);
    pulse_ls();
    repeat (n + 4) @(posedge clk);
    @(negedge clk);
    check("restart_drained", exp_q.size(), 0);
  endtask

  initial begin
    int r, n;
    logic [1:0] op;
    rst_n = 1'b0; line_start = 1'b0; upd_req = 1'b0;
    upd_op = '0; upd_x = '0; upd_y = '0;
    mhx = '0; mhy = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_length", int'(length), 0);
    check("rst_full", int'(full), 0);
    check("rst_head_x", int'(head_x), 0);
    check("rst_head_y", int'(head_y), 0);
    check("rst_ack", int'(upd_ack), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wdata", int'(mem_wdata), 0);
    check("rst_valid", int'(snake_valid), 0);

    // Empty snake: line_start is ignored.
    pulse_ls();
    repeat (10) begin
      @(negedge clk);
      check("empty_no_valid", int'(snake_valid), 0);
      check("empty_no_ack", int'(upd_ack), 0);
    end
    check("empty_length", int'(length), 0);

    do_upd(2'd0, 5'd3, 4'd4, 1'b0);
    do_upd(2'd1, 5'd4, 4'd4, 1'b0);
    do_upd(2'd1, 5'd5, 4'd4, 1'b0);
    do_scan();

    // Scan beats a simultaneous update.
    do_upd(2'd1, 5'd6, 4'd4, 1'b1);
    @(negedge clk);
    check("collide_drained", exp_q.size(), 0);
    do_scan();

    // Fill to capacity, overflow pushes, then wrap the head pointer.
    do_upd(2'd0, 5'd1, 4'd1, 1'b0);
    for (int i = 2; i <= 7; i++) do_upd(2'd1, 5'(i), 4'd1, 1'b0);
    do_scan();
    do_upd(2'd2, 5'd0, 4'd0, 1'b0);
    do_upd(2'd1, 5'd9, 4'd9, 1'b0);
    do_scan();

    // Single segment: pop is refused, reserved op is a no-op.
    do_upd(2'd0, 5'd7, 4'd2, 1'b0);
    do_upd(2'd2, 5'd0, 4'd0, 1'b0);
    do_upd(2'd3, 5'd31, 4'd15, 1'b0);
    do_scan();
    do_restart(2);

    do_upd(2'd1, 5'd8, 4'd2, 1'b0);
    do_upd(2'd1, 5'd9, 4'd2, 1'b0);
    do_restart(2);
    do_restart(3);
    do_restart(4);

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (body.size() == 0) op = 2'd0;
      else if (r < 50) op = 2'd1;
      else if (r < 80) op = 2'd2;
      else if (r < 92) op = 2'd0;
      else op = 2'd3;
      do_upd(op, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
      r = $urandom_range(0, 9);
      n = body.size();
      if (r < 3) do_scan();
      else if (r == 3) do_restart($urandom_range(2, n + 1));
    end

    // Asynchronous reset in the middle of a scan.
    do_upd(2'd0, 5'd10, 4'd3, 1'b0);
    do_upd(2'd1, 5'd11, 4'd3, 1'b0);
    do_upd(2'd1, 5'd12, 4'd3, 1'b0);
    push_beats(body.size());
    pulse_ls();
    @(negedge clk);
    @(negedge clk);
    #2;
    exp_q.delete();
    body.delete();
    mhx = '0; mhy = '0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(snake_valid), 0);
    check("arst_first", int'(snake_first), 0);
    check("arst_last", int'(snake_last), 0);
    check("arst_ack", int'(upd_ack), 0);
    check("arst_we", int'(mem_we), 0);
    check("arst_addr", int'(mem_addr), 0);
    check("arst_wdata", int'(mem_wdata), 0);
    check("arst_length", int'(length), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_valid", int'(snake_valid), 0);
    end
    check("post_rst_length", int'(length), 0);
    check("post_rst_full", int'(full), 0);

    do_upd(2'd0, 5'd2, 4'd5, 1'b0);
    do_scan();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/snake_mem_scheduler.md
Name: snake_mem_scheduler

Overview:
- Owns the snake body RAM, a circular buffer of segment coordinates.
- Shares the single RAM port between two requesters:
  - game-logic updates: init, push head, pop tail;
  - a per-scanline streaming scan that feeds the VGA row-buffer builder with snake_x/snake_y/snake_first/snake_last/snake_valid.
- Sits between the game FSM, the VGA sync generator (line_start) and the VGA renderer.

Parameters:
- MAX_LEN, 64, capacity in segments; any value 2..256.
- ADDR_W, $clog2(MAX_LEN), RAM address width.

Ports:
- clk  input  1  system clock (pixel clock).
- rst_n  input  1  asynchronous, active-low reset.
- line_start  input  1  one-cycle pulse from VGA sync when next_py changes; requests a full scan.
- upd_req  input  1  game-logic update request; held until upd_ack.
- upd_op  input  2  0=INIT, 1=PUSH_HEAD, 2=POP_TAIL, 3=reserved (acked, no effect).
- upd_x  input  5  x tile for INIT/PUSH_HEAD.
- upd_y  input  4  y tile for INIT/PUSH_HEAD.
- upd_ack  output  1  one-cycle pulse when the update is applied.
- full  output  1  length == MAX_LEN.
- length  output  ADDR_W+1  current segment count.
- head_x  output  5  registered head x (last written INIT/PUSH coordinate).
- head_y  output  4  registered head y.
- mem_addr  output  ADDR_W  RAM address.
- mem_we  output  1  RAM write enable.
- mem_wdata  output  9  {y[3:0], x[4:0]}.
- mem_rdata  input  9  RAM read data; synchronous read, valid one cycle after mem_addr.
- snake_x  output  5  streamed segment x = mem_rdata[4:0].
- snake_y  output  4  streamed segment y = mem_rdata[8:5].
- snake_valid  output  1  snake_x/snake_y valid this cycle.
- snake_first  output  1  marks the tail (oldest) segment of the scan.
- snake_last  output  1  marks the head segment of the scan.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; head_ptr=0, tail_ptr=0, length=0, head_x=0, head_y=0.
  - upd_ack, mem_we, snake_valid, snake_first, snake_last, mem_addr and mem_wdata all 0.
  - Reset mid-scan or mid-write aborts immediately; there is no partial output after release.
- Pointers:
  - Increment wraps explicitly from MAX_LEN-1 to 0; power-of-two MAX_LEN is not assumed.
  - Live segments run tail_ptr..head_ptr inclusive.
- States:
  - IDLE: on line_start with length>0, go to SCAN with scan_ptr=tail_ptr and scan_cnt=length.
    - Otherwise, if upd_req, go to UPD.
    - line_start together with upd_req: the scan wins; the update waits.
    - line_start with length=0: ignored, stay IDLE, no stream output.
  - SCAN:
    - Each cycle: mem_addr=scan_ptr, mem_we=0, scan_ptr++, scan_cnt--.
    - When scan_cnt reaches 0 after the issue, go to IDLE.
    - Exactly length issue cycles per scan.
    - line_start during SCAN restarts from tail_ptr with a fresh count. Reads already in flight still emerge; first is marked on the new first issue.
  - UPD: one cycle, then upd_ack=1 for exactly one cycle, then IDLE.
    - INIT: head_ptr=0, tail_ptr=0, length=1, write upd coords at address 0, head_x/head_y updated.
    - PUSH_HEAD, not full: write at head_ptr+1, head_ptr++, length++, head_x/head_y updated.
    - PUSH_HEAD when full: no write, no state change, still acked.
    - POP_TAIL with length>1: tail_ptr++, length--, no RAM access.
    - POP_TAIL with length<=1: no change, acked.
- Stream pipeline:
  - Each issue cycle sets a registered valid_d with first_d (first issue of the scan) and last_d (the scan_cnt==1 issue).
  - The next cycle: snake_valid=valid_d, snake_first=first_d, snake_last=last_d, with snake_x/y taken combinationally from mem_rdata.
  - Latency from line_start to first snake_valid: 2 cycles (IDLE→SCAN register, then RAM read).
  - For length=1, snake_first and snake_last are both asserted on the same beat.
- Bandwidth:
  - A scan takes ≤ MAX_LEN+1 cycles, well below the 800-clock line.
  - Worst-case update wait is one scan. upd_req must stay stable until upd_ack.
- length, full, head_x and head_y are registered and change in the cycle after the UPD state.

Test Plan:
- Reset then line_start → no snake_valid for 10 cycles; length=0, upd_ack never asserted.
- INIT(3,4), PUSH(4,4), PUSH(5,4), then line_start → 3 valid beats 2..4 cycles after the pulse: (3,4) first=1, (4,4), (5,4) last=1; length=3, head=(5,4).
- line_start and upd_req(PUSH 6,4) in the same cycle → the 3-beat scan completes first; upd_ack follows the scan; the next scan gives 4 beats ending (6,4).
- MAX_LEN=4: INIT plus 5 PUSHes → full=1 after the 3rd push; the 4th and 5th pushes are acked with length held at 4. Then POP, PUSH(9,9) → the scan shows wrap-around order, with the tail at the former segment 1 and the head (9,9).
- POP_TAIL at length=1 → acked, length stays 1. A scan shows a single beat with first=last=1.
- rst_n low for one cycle mid-scan → all outputs 0 asynchronously; after release no further valid beats; length=0.
